// File: rtl/trace_repository_datatypes.sv
// Shared types for the trace repository and its replay-phase consumers.
// Entry layout, dispatcher states and opcode constants live here.
package trace_repository_datatypes;

  localparam int TRACE_ENTRIES = 16;
  localparam int TIDX          = $clog2(TRACE_ENTRIES);
  localparam int REPO_ADDR_W   = 16;
  localparam int REPO_DATA_W   = 32;

  typedef struct packed {
    logic [REPO_ADDR_W-1:0] mem_addr;
    logic [REPO_DATA_W-1:0] instruction;
  } trace_repo_data_entry;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_ENTRY,
    ST_CANCEL_WAIT,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_MARK,
    ST_DONE
  } dispatch_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    PF_NONE,
    PF_LOAD,
    PF_STORE
  } prefetch_kind_t;

endpackage

// File: rtl/trace_opcode_decoder.sv
// Classifies a RISC-V instruction as load, store or non-memory.
// Purely combinational; reused by later analysis blocks.
module trace_opcode_decoder
  import trace_repository_datatypes::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] instr_i,
  output logic         is_mem_o,
  output logic         is_store_o
);

  logic [6:0] opc;
  logic       unused_hi;

  assign opc       = instr_i[6:0];
  assign unused_hi = ^instr_i[W-1:7];

  always_comb begin
    is_mem_o   = 1'b0;
    is_store_o = 1'b0;
    unique case (1'b1)
      (opc == OPC_LOAD): is_mem_o = 1'b1;
      (opc == OPC_STORE): begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trace_prefetch_dispatcher.sv
// Replay-phase consumer: pulls trace entries, issues data prefetches
// for loads/stores and retires each entry through mark_done.
module trace_prefetch_dispatcher
  import trace_repository_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_DATA_WIDTH = 32,
  parameter int CANCEL_TIMEOUT  = 16,
  parameter int MEM_TIMEOUT     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lock,
  output logic                       trace_req,
  output logic                       cancel,
  input  trace_repo_data_entry       trace_in,
  input  logic [TIDX-1:0]            trace_index_i,
  input  logic                       entry_valid,
  input  logic                       cancelled,
  input  logic                       processing_complete,
  output logic [TIDX-1:0]            index_done,
  output logic                       mark_done,
  output logic                       processing_flag,
  output logic                       mem_trace_flag,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                       mark_done_valid,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [15:0]                prefetch_count_o
);

  if (CANCEL_TIMEOUT < 1 || CANCEL_TIMEOUT > 255 ||
      MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("timeouts must lie in 1..255 for the 8-bit timer");
  end

  localparam logic [7:0] CANCEL_LAST = 8'(CANCEL_TIMEOUT - 1);
  localparam logic [7:0] MEM_LAST    = 8'(MEM_TIMEOUT - 1);

  dispatch_state_t             state_q, state_d;
  logic [7:0]                  timer_q, timer_d;
  logic [DATA_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [TIDX-1:0]             idx_q, idx_d;
  prefetch_kind_t              kind_q, kind_d;
  logic                        flag_q, flag_d;
  logic                        done_q, done_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        req_q, req_d;
  logic                        cancel_q, cancel_d;
  logic                        mreq_q, mreq_d;
  logic                        we_q, we_d;
  logic                        mark_q, mark_d;
  logic                        pflag_q, pflag_d;
  logic [TIDX-1:0]             xidx_q, xidx_d;
  logic [DATA_ADDR_WIDTH-1:0]  xaddr_q, xaddr_d;
  logic                        busy_q, busy_d;
  logic                        dec_mem, dec_store;

  trace_opcode_decoder #(
    .W (DATA_DATA_WIDTH)
  ) u_dec (
    .instr_i    (trace_in.instruction),
    .is_mem_o   (dec_mem),
    .is_store_o (dec_store)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    flag_d  = flag_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (lock && !done_q) state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT_ENTRY;
      ST_WAIT_ENTRY, ST_CANCEL_WAIT: begin
        if (state_q == ST_WAIT_ENTRY && processing_complete) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (entry_valid) begin
          addr_d  = DATA_ADDR_WIDTH'(trace_in.mem_addr);
          idx_d   = trace_index_i;
          kind_d  = dec_store ? PF_STORE : (dec_mem ? PF_LOAD : PF_NONE);
          flag_d  = 1'b0;
          state_d = dec_mem ? ST_MEM_REQ : ST_MARK;
        end else if (state_q == ST_WAIT_ENTRY) begin
          if (timer_q == CANCEL_LAST) state_d = ST_CANCEL_WAIT;
        end else if (cancelled) begin
          state_d = ST_REQUEST;
        end
      end
      ST_MEM_REQ, ST_MEM_WAIT: begin
        if ((state_q == ST_MEM_WAIT || mem_gnt_i) && mem_rvalid_i) begin
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          flag_d  = 1'b1;
          state_d = ST_MARK;
        end else if (state_q == ST_MEM_REQ) begin
          if (mem_gnt_i) state_d = ST_MEM_WAIT;
        end else if (timer_q == MEM_LAST) begin
          flag_d  = 1'b0;
          state_d = ST_MARK;
        end
      end
      ST_MARK: if (mark_done_valid) state_d = lock ? ST_REQUEST : ST_IDLE;
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    // Dropping lock aborts everything except an unacknowledged retire.
    if (!lock && state_q != ST_MARK) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
    timer_d  = (state_d != state_q) ? 8'd0 : timer_q + 8'd1;
    req_d    = (state_d == ST_REQUEST) || (state_d == ST_WAIT_ENTRY);
    cancel_d = (state_d == ST_CANCEL_WAIT);
    mreq_d   = (state_d == ST_MEM_REQ);
    we_d     = mreq_d && (kind_d == PF_STORE);
    mark_d   = (state_d == ST_MARK);
    pflag_d  = mark_d && flag_d;
    xidx_d   = mark_d ? idx_d : '0;
    xaddr_d  = (mark_d || mreq_d) ? addr_d : '0;
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      kind_q   <= PF_NONE;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      cancel_q <= 1'b0;
      mreq_q   <= 1'b0;
      we_q     <= 1'b0;
      mark_q   <= 1'b0;
      pflag_q  <= 1'b0;
      xidx_q   <= '0;
      xaddr_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      kind_q   <= kind_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      cancel_q <= cancel_d;
      mreq_q   <= mreq_d;
      we_q     <= we_d;
      mark_q   <= mark_d;
      pflag_q  <= pflag_d;
      xidx_q   <= xidx_d;
      xaddr_q  <= xaddr_d;
      busy_q   <= busy_d;
    end
  end

  assign trace_req        = req_q;
  assign cancel           = cancel_q;
  assign index_done       = xidx_q;
  assign mark_done        = mark_q;
  assign processing_flag  = pflag_q;
  assign mem_trace_flag   = mark_q;
  assign mem_addr_o       = xaddr_q;
  assign mem_req_o        = mreq_q;
  assign mem_we_o         = we_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign prefetch_count_o = cnt_q;

endmodule

// File: tb/tb_trace_prefetch_dispatcher.sv
// Directed plus randomized replay traffic against a transaction-level
// model of the dispatcher's retire/prefetch rules.
module tb_trace_prefetch_dispatcher;
  import trace_repository_datatypes::*;

  localparam int CT = 16;
  localparam int MT = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 lock = 1'b0;
  logic                 trace_req, cancel;
  trace_repo_data_entry trace_in = '0;
  logic [TIDX-1:0]      trace_index_i = '0;
  logic                 entry_valid = 1'b0;
  logic                 cancelled = 1'b0;
  logic                 processing_complete = 1'b0;
  logic [TIDX-1:0]      index_done;
  logic                 mark_done, processing_flag, mem_trace_flag;
  logic [15:0]          mem_addr_o;
  logic                 mark_done_valid = 1'b0;
  logic                 mem_req_o, mem_we_o;
  logic                 mem_gnt_i = 1'b0;
  logic                 mem_rvalid_i = 1'b0;
  logic                 busy_o, done_o;
  logic [15:0]          prefetch_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  trace_prefetch_dispatcher #(
    .DATA_ADDR_WIDTH (16),
    .DATA_DATA_WIDTH (32),
    .CANCEL_TIMEOUT  (CT),
    .MEM_TIMEOUT     (MT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lock                (lock),
    .trace_req           (trace_req),
    .cancel              (cancel),
    .trace_in            (trace_in),
    .trace_index_i       (trace_index_i),
    .entry_valid         (entry_valid),
    .cancelled           (cancelled),
    .processing_complete (processing_complete),
    .index_done          (index_done),
    .mark_done           (mark_done),
    .processing_flag     (processing_flag),
    .mem_trace_flag      (mem_trace_flag),
    .mem_addr_o          (mem_addr_o),
    .mark_done_valid     (mark_done_valid),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .prefetch_count_o    (prefetch_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int c;
    c = 0;
    while (trace_req !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    chk({tag, "_req_seen"}, 32'(trace_req), 32'd1);
  endtask

  task automatic present(input logic [15:0] a, input logic [31:0] ins,
                         input logic [TIDX-1:0] ix);
    wait_req("ent");
    tick();
    trace_in      = {a, ins};
    trace_index_i = ix;
    entry_valid   = 1'b1;
    tick();
    entry_valid   = 1'b0;
  endtask

  // gd: cycles before grant; rd: 0 = with grant, k = k-th wait cycle
  task automatic run_entry(input logic [15:0] a, input logic [31:0] ins,
                           input logic [TIDX-1:0] ix, input int gd,
                           input int rd, input int ackd);
    logic is_st, is_mem, flag;
    int c;
    is_st  = (ins[6:0] == 7'h23);
    is_mem = is_st || (ins[6:0] == 7'h03);
    flag   = 1'b0;
    present(a, ins, ix);
    chk("req_drop", 32'(trace_req), 32'd0);
    if (is_mem) begin
      chk("mem_req", 32'(mem_req_o), 32'd1);
      chk("mem_addr", 32'(mem_addr_o), 32'(a));
      chk("mem_we", 32'(mem_we_o), 32'(is_st));
      for (int i = 0; i < gd; i++) begin
        tick();
        chk("mem_req_hold", 32'(mem_req_o), 32'd1);
      end
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (rd == 0);
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      chk("mem_req_drop", 32'(mem_req_o), 32'd0);
      if (rd == 0) begin
        flag = 1'b1;
      end else begin
        c = 1;
        while (mark_done !== 1'b1 && c <= MT + 5) begin
          mem_rvalid_i = (c == rd);
          tick();
          mem_rvalid_i = 1'b0;
          c++;
        end
        flag = (rd <= MT);
        chk("mem_wait_len", 32'(c - 1), 32'(flag ? rd : MT));
      end
      if (flag) exp_cnt++;
    end else begin
      chk("no_mem_req", 32'(mem_req_o), 32'd0);
    end
    chk("mark_done", 32'(mark_done), 32'd1);
    chk("trace_flag", 32'(mem_trace_flag), 32'd1);
    chk("index_done", 32'(index_done), 32'(ix));
    chk("mark_addr", 32'(mem_addr_o), 32'(a));
    chk("proc_flag", 32'(processing_flag), 32'(flag));
    chk("count", 32'(prefetch_count_o), 32'(exp_cnt));
    for (int i = 0; i < ackd; i++) begin
      tick();
      chk("mark_hold", 32'(mark_done), 32'd1);
    end
    mark_done_valid = 1'b1;
    tick();
    mark_done_valid = 1'b0;
    chk("mark_drop", 32'(mark_done), 32'd0);
    chk("req_again", 32'(trace_req), 32'(lock));
  endtask

  function automatic logic [31:0] mk_instr(input int kind);
    logic [31:0] r;
    r = $urandom;
    if (kind == 0) r[6:0] = 7'h03;
    else if (kind == 1) r[6:0] = 7'h23;
    else if (r[6:0] == 7'h03 || r[6:0] == 7'h23) r[6:0] = 7'h13;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, rd;
    // reset state
    tick();
    chk("rst_req", 32'(trace_req), 32'd0);
    chk("rst_mark", 32'(mark_done), 32'd0);
    chk("rst_memreq", 32'(mem_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_count", 32'(prefetch_count_o), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("unlocked_idle", 32'(busy_o | trace_req), 32'd0);
    lock = 1'b1;
    tick();
    chk("lock_req", 32'(trace_req), 32'd1);
    chk("lock_busy", 32'(busy_o), 32'd1);

    // load with delayed grant and response
    run_entry(16'h0040, 32'h0000A283, 4'd3, 2, 3, 1);
    // non-memory instruction retires directly
    run_entry(16'h0200, 32'h00100093, 4'd5, 0, 0, 0);

    // cancel after the wait budget expires
    wait_req("cxl");
    c = 0;
    while (cancel !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    chk("cancel_latency", 32'(c), 32'(CT + 1));
    chk("cancel_req_low", 32'(trace_req), 32'd0);
    tick();
    chk("cancel_hold", 32'(cancel), 32'd1);
    cancelled = 1'b1;
    tick();
    cancelled = 1'b0;
    chk("cancel_drop", 32'(cancel), 32'd0);
    chk("cancel_rereq", 32'(trace_req), 32'd1);

    // store whose response never arrives
    run_entry(16'h0100, 32'h00512023, 4'd7, 0, 1000, 0);

    // randomized traffic
    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) rd = r;
      else if (r == 7) rd = MT;
      else rd = MT + 1;
      run_entry(16'($urandom), mk_instr($urandom_range(0, 2)),
                TIDX'($urandom), $urandom_range(0, 3), rd,
                $urandom_range(0, 2));
    end

    // repository exhausted
    wait_req("pc");
    tick();
    processing_complete = 1'b1;
    tick();
    processing_complete = 1'b0;
    chk("pc_req_low", 32'(trace_req), 32'd0);
    chk("pc_done", 32'(done_o), 32'd1);
    chk("pc_busy", 32'(busy_o), 32'd0);
    repeat (3) tick();
    chk("pc_no_req", 32'(trace_req), 32'd0);
    chk("pc_sticky", 32'(done_o), 32'd1);
    lock = 1'b0;
    tick();
    chk("unlock_done", 32'(done_o), 32'd0);
    lock = 1'b1;
    tick();
    chk("relock_req", 32'(trace_req), 32'd1);

    // async reset while requesting memory
    present(16'h0300, 32'h00002003, 4'd2);
    chk("pre_rst_memreq", 32'(mem_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_memreq_drop", 32'(mem_req_o), 32'd0);
    chk("rst_memreq_busy", 32'(busy_o), 32'd0);
    chk("rst_memreq_cnt", 32'(prefetch_count_o), 32'd0);
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;

    // async reset while retiring
    present(16'h0400, 32'h00000013, 4'd9);
    chk("pre_rst_mark", 32'(mark_done), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mark_drop", 32'(mark_done), 32'd0);
    chk("rst_mark_busy", 32'(busy_o), 32'd0);
    chk("rst_mark_cnt", 32'(prefetch_count_o), 32'd0);
    tick();
    rst_n = 1'b1;
    run_entry(16'h0500, 32'h0000A283, 4'd1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
